// File: rtl/ysyx_brq_pkg.sv
// Shared types and defaults for the branch-resolution queue.
// Holds the FSM state encoding and the default sizing constants.
// No logic; imported by every file of the block.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif
`ifndef YSYX_PC_INIT
`define YSYX_PC_INIT 32'h8000_0000
`endif

package ysyx_brq_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } brq_state_e;

   localparam int BRQ_DEPTH_DEF     = 4;
   localparam int BRQ_FLUSH_CYC_DEF = 2;

endpackage

// File: rtl/ysyx_brq_fifo.sv
// Circular storage of in-flight predictions with occupancy count and clear.
// Latency: push visible at head next cycle; head is a combinational read at rd_ptr.
// Backpressure: none internally; caller gates push/pop with count (clear wins over push/pop).
module ysyx_brq_fifo
   import ysyx_brq_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = BRQ_DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Entry storage; contents are never reset, a clear simply drops the write
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; clear empties by catching rd up to wr
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ysyx_brq.sv
// Branch-resolution queue: checks in-order EXU resolutions against queued IFU predictions.
// Latency: good/bad/redirect/counters registered, visible the cycle after the resolve.
// Backpressure: push_ready/res_ready decoded from state and count only; both low during FLUSH.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif
`ifndef YSYX_PC_INIT
`define YSYX_PC_INIT 32'h8000_0000
`endif

module ysyx_brq
   import ysyx_brq_pkg::*;
#(
   parameter int DATA_W    = `YSYX_W_WIDTH,
   parameter int DEPTH     = BRQ_DEPTH_DEF,
   parameter int FLUSH_CYC = BRQ_FLUSH_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_valid,
   input  logic [DATA_W-1:0] push_pc,
   input  logic [DATA_W-1:0] push_pred,
   output logic              push_ready,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_npc,
   output logic              res_ready,
   output logic              good_speculation,
   output logic              bad_speculation,
   output logic [DATA_W-1:0] redirect_pc,
   output logic              flush_o,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);

   brq_state_e          state;
   logic [FC_W-1:0]     flush_cnt;
   logic [CNT_W-1:0]    count;
   logic [2*DATA_W-1:0] head;
   logic [DATA_W-1:0]   head_pred;
   logic [DATA_W-1:0]   head_pc_unused;
   logic                push_fire;
   logic                res_fire;
   logic                pred_eq;
   logic                hit;
   logic                miss;
   logic [31:0]         hit_nxt;
   logic [31:0]         miss_nxt;

   // Ready depends on state and occupancy only, so a same-cycle pop never frees a slot
   assign push_ready = (state == RUN) && (count < DEPTH_CNT);
   assign res_ready  = (state == RUN) && (count != '0);
   assign push_fire  = push_valid && push_ready;
   assign res_fire   = res_valid && res_ready;

   assign {head_pc_unused, head_pred} = head;
   assign pred_eq = (res_npc == head_pred);
   assign hit     = res_fire && pred_eq;
   assign miss    = res_fire && !pred_eq;

   ysyx_brq_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_fire),
      .din   ({push_pc, push_pred}),
      .pop   (hit),
      .clear (miss),
      .head  (head),
      .count (count)
   );

   // Saturating next values for the hit/miss statistics
   always_comb begin
      hit_nxt  = hit_cnt;
      miss_nxt = miss_cnt;
      if (hit && (hit_cnt != 32'hFFFF_FFFF))   hit_nxt  = hit_cnt + 32'd1;
      if (miss && (miss_cnt != 32'hFFFF_FFFF)) miss_nxt = miss_cnt + 32'd1;
   end

   // RUN/FLUSH control: a mispredict holds the queue closed for FLUSH_CYC cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         flush_cnt <= '0;
         flush_o   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (miss) begin
                  state     <= FLUSH;
                  flush_cnt <= FLUSH_LOAD;
                  flush_o   <= 1'b1;
               end
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  state   <= RUN;
                  flush_o <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: begin
               state   <= RUN;
               flush_o <= 1'b0;
            end
         endcase
      end
   end

   // Resolution outcome pulses, redirect target and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         good_speculation <= 1'b0;
         bad_speculation  <= 1'b0;
         redirect_pc      <= DATA_W'(`YSYX_PC_INIT);
         hit_cnt          <= '0;
         miss_cnt         <= '0;
      end else begin
         good_speculation <= hit;
         bad_speculation  <= miss;
         if (miss) redirect_pc <= res_npc;
         hit_cnt          <= hit_nxt;
         miss_cnt         <= miss_nxt;
      end
   end

endmodule

// File: doc/ysyx_brq.md
YSYX_BRQ -- requirements
Module: ysyx_brq

Interface
REQ-001 Parameter DATA_W, default `YSYX_W_WIDTH, SHALL set the PC/target width.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2), SHALL set the in-flight prediction queue depth.
REQ-003 Parameter FLUSH_CYC, default 2 (>=1), SHALL set the number of cycles the FLUSH state is held.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 push_valid  in  1  IFU offers a predicted control-flow instruction.
REQ-007 push_pc  in  DATA_W  PC of the offered instruction.
REQ-008 push_pred  in  DATA_W  predicted next PC of the offered instruction.
REQ-009 push_ready  out  1  queue accepts a push this cycle.
REQ-010 res_valid  in  1  EXU resolves the oldest queued instruction, in program order.
REQ-011 res_npc  in  DATA_W  actual next PC of the resolved instruction.
REQ-012 res_ready  out  1  a resolve is accepted this cycle.
REQ-013 good_speculation  out  1  one-cycle pulse: the resolved prediction matched.
REQ-014 bad_speculation  out  1  one-cycle pulse: the resolved prediction mismatched.
REQ-015 redirect_pc  out  DATA_W  correct next PC; valid while bad_speculation=1, else holds its last value.
REQ-016 flush_o  out  1  asserted throughout the FLUSH state.
REQ-017 hit_cnt, miss_cnt  out  32 each  saturating counts of good and bad resolutions.

Function
REQ-018 The queue SHALL be a DEPTH-entry circular FIFO of {pc, pred}, with wr_ptr/rd_ptr wrapping modulo DEPTH and an occupancy count 0..DEPTH.
REQ-019 push_ready SHALL be 1 only when state=RUN and count<DEPTH; a push fires on push_valid & push_ready.
REQ-020 res_ready SHALL be 1 only when state=RUN and count>0; a resolve fires on res_valid & res_ready.
REQ-021 A resolve SHALL compare res_npc against the head entry's pred over all DATA_W bits.
REQ-022 On a match, the block SHALL register good_speculation=1 for the next cycle, pop the head, and increment hit_cnt.
REQ-023 On a mismatch, the block SHALL register, for the next cycle, bad_speculation=1, redirect_pc=res_npc, and miss_cnt+1.
REQ-024 On a mismatch, the block SHALL also clear the queue (count=0, rd_ptr=wr_ptr) and enter FLUSH.
REQ-025 The FSM SHALL have two states, RUN and FLUSH.
REQ-026 RUN->FLUSH SHALL occur only on a mismatching resolve; the flush counter loads FLUSH_CYC-1.
REQ-027 FLUSH SHALL decrement the counter each cycle and return to RUN in the cycle after the counter reads 0, so FLUSH lasts exactly FLUSH_CYC cycles.
REQ-028 flush_o SHALL equal (state==FLUSH); push and resolve are refused in FLUSH.
REQ-029 A push and a matching resolve in the same cycle SHALL both take effect: count unchanged, both pointers advance.
REQ-030 A push and a mismatching resolve in the same cycle SHALL apply the mismatch clear first; the pushed entry is discarded and count=0.
REQ-031 A full queue SHALL refuse a push even when a resolve fires in the same cycle; there is no combinational path from res_valid to push_ready.
REQ-032 hit_cnt and miss_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-033 good_speculation and bad_speculation SHALL never be 1 in the same cycle.
REQ-034 All outputs SHALL be registered, except push_ready/res_ready, which are decoded from state and count only.

Reset
REQ-035 On rst=1 the block SHALL set: count, pointers, flush counter, hit_cnt, miss_cnt, good_speculation, bad_speculation = 0.
REQ-036 On rst=1 the block SHALL also set state=RUN and redirect_pc=`YSYX_PC_INIT.
REQ-037 rst SHALL take priority over every other event, including mid-FLUSH and simultaneous push/resolve, and queue contents need not be cleared.

Structure
REQ-038 The state enum {RUN, FLUSH} and the default DEPTH/FLUSH_CYC constants SHALL live in the shared ysyx package header.
REQ-039 The storage and pointers SHALL be one sub-module, ysyx_brq_fifo (push, pop, clear, count), and the FSM, compare and counters stay in ysyx_brq.

Verification
REQ-040 Reset, then push {pc=0x8000_0000, pred=0x8000_0010}, resolve res_npc=0x8000_0010 -> good_speculation=1 one cycle later, hit_cnt=1, count=0.
REQ-041 Push pred=0x8000_0010, resolve res_npc=0x8000_0004 -> bad_speculation=1 and redirect_pc=0x8000_0004 one cycle; flush_o=1 for exactly 2 cycles; push_ready=0 during flush.
REQ-042 Push 4 entries without resolve -> push_ready=0, and a 5th push_valid is ignored; resolve 4 matching entries -> 4 good pulses in order, count=0; repeat 3 times to exercise pointer wrap.
REQ-043 With count=2, push and matching resolve in the same cycle -> count stays 2; with a mismatch instead, count=0 and the pushed entry is gone.
REQ-044 Assert rst in the first FLUSH cycle -> next cycle state=RUN, flush_o=0, all counters 0, res_ready=0.
REQ-045 Preload miss_cnt at 32'hFFFF_FFFF (force), then mismatch -> miss_cnt stays 32'hFFFF_FFFF.
